mcp3008_responder: RTL and testbench
====================================

// Module: mcp3008_responder
// PURPOSE
// - Synthesizable MCP3008-compatible SPI responder (ADC end of the AD_CLK/CS/DIN/DOUT link).
// - Answers conversion requests from the controller's bit-banged ADC master with values from a channel register bank.
// - Used for hardware-in-the-loop throttle/battery emulation.
// - The 3-wire SPI inputs are asynchronous to clk: they are synchronized internally and edge-detected.
// PARAMETERS
// SYNC_STAGES  2   flops per synchronizer on sclk/cs_n/din (>=2)
// DATA_W       10  conversion result width (fixed MCP3008 format)
// PORTS
// clk          in   1       system clock (50 MHz); sole clock
// rst          in   1       asynchronous reset, active-high
// sclk         in   1       SPI clock from master (AD_CLK)
// cs_n         in   1       chip select, active-low
// din          in   1       command from master
// dout         out  1       result to master; valid only when dout_oe=1
// dout_oe      out  1       output enable (1 = driving; 0 = hi-Z at pad)
// ch_data      in   80      channel bank, ch[i] = ch_data[10*i+9 -: 10]
// conv_done    out  1       1-clk pulse: last MSB-first bit (B0) driven
// last_ch      out  3       channel field {D2,D1,D0} of the most recent conversion
// last_sgl     out  1       SGL/DIFF bit of the most recent conversion
// BEHAVIOUR
// - Reset: dout=0, dout_oe=0, conv_done=0, last_ch=0, last_sgl=0, state=IDLE, sync flops=1 (cs_n idle high).
// - Edge detection: rise/fall = transition between the last two synchronizer stages; one clk pulse each.
// - DIN sampling: din is taken from the synchronized din one clk BEFORE the detected sclk rise.
//   This is the value present before the edge, which is required because the master changes din on the same edge.
// - Timing requirement: sclk high/low time >= SYNC_STAGES+3 clk. dout changes exactly SYNC_STAGES+1 clk after a raw sclk fall.
// - cs_n high (synced level) in any state: state=IDLE, dout_oe=0, dout=0 on the next clk; any partial transaction is discarded.
// - FSM (advances only on sclk edges while cs_n low):
//   IDLE: cs_n fall -> WAIT_START.
//   WAIT_START: on each rise, din=0 -> stay; din=1 -> CMD with cmd_cnt=0.
//   CMD: 4 rises capture SGL, D2, D1, D0 MSB first. After the D0 rise -> SAMPLE, and the result is latched:
//     SGL=1: result = ch[{D2,D1,D0}].
//     SGL=0: pos = ch[{D2,D1,D0}], neg = ch[{D2,D1,D0}^1].
//       result = (pos>neg) ? pos-neg : 0, computed in 11-bit signed and clamped to 10 bits.
//     last_ch and last_sgl are updated at the same time.
//   SAMPLE: next fall -> dout_oe=1, dout=0 (null bit) -> MSB.
//   MSB: each fall drives result[9], [8] ... [0]. With B0 driven: pulse conv_done, then -> TAIL.
//   TAIL: each fall drives the tail bits (see CONFIGURATION); it holds until cs_n rises.
// - Rise and fall in the same clk is impossible by the sclk timing requirement; it is not handled.
// - A cs_n rise in the same clk as an sclk edge: cs_n wins and the edge is ignored.
// - ch_data is sampled only at the latch point; changes mid-transfer do not affect the bits being shifted.
// - rst asserted mid-transfer: immediately returns to reset values. After release, the FSM needs a fresh cs_n fall, even if cs_n is already low.
// CONFIGURATION
// MCP3008_LSB_TAIL_EN defined:
//   TAIL drives result[1], [2] ... [9] (LSB-first repeat, per datasheet), then 0 on all further falls.
// MCP3008_LSB_TAIL_EN undefined:
//   TAIL drives 0 on every fall.
//   dout_oe stays 1 in TAIL either way.
// TESTING
// 1. Single-ended: ch[5]=10'h2A5, master sends 1,1,1,0,1 (start,SGL,D2..D0).
//    Null bit=0, then 1010100101 MSB first. conv_done pulses once; last_ch=5, last_sgl=1.
// 2. Differential: ch[2]=700, ch[3]=200, cmd SGL=0, D=010 -> result 500 (10'h1F4).
//    Swap to ch[2]=200, ch[3]=700 -> result 0.
// 3. Tail: ch[1]=10'h301, 30 sclk with cs_n low.
//    With MCP3008_LSB_TAIL_EN: bits after B0 are 0,0,0,0,0,0,0,1,1, then zeros.
//    Without the macro: all zeros after B0.
// 4. Abort: cs_n rises after D1 -> dout_oe=0 within SYNC_STAGES+2 clk, no conv_done.
//    The next full request for ch[0]=10'h3FF returns 1111111111.
// 5. Leading zeros/sweep: 8 idle 0 bits before start; loop ch 0..7 with ch[i]=i*100.
//    Each result equals i*100; last_ch tracks i.
// 6. Reset mid-MSB phase: dout_oe=0, dout=0 immediately.
//    With cs_n held low, no response until a cs_n high->low cycle.

Source files
------------

// File: rtl/mcp3008_responder.sv
// MCP3008-compatible SPI responder: answers 3-wire conversion requests from a channel register bank.
// Optional LSB-first tail repeat after B0 is enabled by defining MCP3008_LSB_TAIL_EN.
module mcp3008_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  din,
  output logic                  dout,
  output logic                  dout_oe,
  input  logic [8*DATA_W-1:0]   ch_data,
  output logic                  conv_done,
  output logic [2:0]            last_ch,
  output logic                  last_sgl
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_START = 3'd1;
  localparam logic [2:0] CMD        = 3'd2;
  localparam logic [2:0] SAMPLE     = 3'd3;
  localparam logic [2:0] MSB        = 3'd4;
  localparam logic [2:0] TAIL       = 3'd5;

  logic [SYNC_STAGES:0]   sclk_sync;
  logic [SYNC_STAGES:0]   cs_sync;
  logic [SYNC_STAGES:0]   prime;
  logic [SYNC_STAGES-1:0] din_sync;
  logic                   din_prev;

  logic [2:0]        state;
  logic [1:0]        cmd_cnt;
  logic [2:0]        cmd_sr;
  logic [3:0]        bit_idx;
  logic [DATA_W-1:0] result;
`ifdef MCP3008_LSB_TAIL_EN
  logic [3:0]        tail_cnt;
`endif

  logic       sclk_rise;
  logic       sclk_fall;
  logic       cs_high;
  logic       cs_fall;
  logic [2:0] chan;

  function automatic logic [DATA_W-1:0] ch_sel(input logic [2:0] idx);
    return ch_data[DATA_W*idx +: DATA_W];
  endfunction

  // Unipolar clamp of the pseudo-differential result: negative differences read as zero.
  function automatic logic [DATA_W-1:0] sat_diff(input logic [DATA_W-1:0] pos,
                                                  input logic [DATA_W-1:0] neg);
    logic signed [DATA_W:0] diff;
    diff = $signed({1'b0, pos}) - $signed({1'b0, neg});
    return (diff < 0) ? '0 : diff[DATA_W-1:0];
  endfunction

  // Synchronizers; prime marks when the cs_n chain holds only post-reset samples,
  // so a cs_n already low at reset release cannot look like a fresh fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      din_sync  <= '1;
      din_prev  <= 1'b1;
      prime     <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-1:0], cs_n};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
      din_prev  <= din_sync[SYNC_STAGES-1];
      prime     <= {prime[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_sync[SYNC_STAGES];
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_sync[SYNC_STAGES];
  assign cs_high   = cs_sync[SYNC_STAGES-1];
  assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_sync[SYNC_STAGES] & prime[SYNC_STAGES];
  assign chan      = {cmd_sr[1:0], din_prev};

  always_ff @(posedge clk) begin
    if (state == CMD && sclk_rise && !cs_high) begin
      cmd_sr <= {cmd_sr[1:0], din_prev};
      if (cmd_cnt == 2'd3)
        result <= cmd_sr[2] ? ch_sel(chan) : sat_diff(ch_sel(chan), ch_sel(chan ^ 3'd1));
    end
  end

  // Protocol FSM: chip-select high overrides any sclk edge seen in the same clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dout      <= 1'b0;
      dout_oe   <= 1'b0;
      conv_done <= 1'b0;
      last_ch   <= 3'd0;
      last_sgl  <= 1'b0;
      cmd_cnt   <= 2'd0;
      bit_idx   <= 4'd0;
`ifdef MCP3008_LSB_TAIL_EN
      tail_cnt  <= 4'd0;
`endif
    end else begin
      conv_done <= 1'b0;
      if (cs_high) begin
        state   <= IDLE;
        dout    <= 1'b0;
        dout_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: if (cs_fall) state <= WAIT_START;
          WAIT_START: begin
            if (sclk_rise && din_prev) begin
              state   <= CMD;
              cmd_cnt <= 2'd0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              cmd_cnt <= cmd_cnt + 2'd1;
              if (cmd_cnt == 2'd3) begin
                state    <= SAMPLE;
                last_ch  <= chan;
                last_sgl <= cmd_sr[2];
              end
            end
          end
          SAMPLE: begin
            if (sclk_fall) begin
              state   <= MSB;
              dout_oe <= 1'b1;
              dout    <= 1'b0;
              bit_idx <= 4'(DATA_W - 1);
            end
          end
          MSB: begin
            if (sclk_fall) begin
              dout <= result[bit_idx];
              if (bit_idx == 4'd0) begin
                conv_done <= 1'b1;
                state     <= TAIL;
`ifdef MCP3008_LSB_TAIL_EN
                tail_cnt  <= 4'd1;
`endif
              end else begin
                bit_idx <= bit_idx - 4'd1;
              end
            end
          end
          TAIL: begin
            if (sclk_fall) begin
`ifdef MCP3008_LSB_TAIL_EN
              if (tail_cnt < 4'(DATA_W)) begin
                dout     <= result[tail_cnt];
                tail_cnt <= tail_cnt + 4'd1;
              end else begin
                dout <= 1'b0;
              end
`else
              dout <= 1'b0;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcp3008_responder.sv
// Bench for mcp3008_responder: bit-banged SPI master, random channel banks, stream-level reference model.
// Follows MCP3008_LSB_TAIL_EN the same way as the design.
module tb_mcp3008_responder;
  localparam int S    = 2;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        cs_n;
  logic        din;
  logic        dout;
  logic        dout_oe;
  logic [79:0] ch_data;
  logic        conv_done;
  logic [2:0]  last_ch;
  logic        last_sgl;

  int chv [8];
  int total = 0;
  int bad = 0;
  int conv_cnt = 0;

  mcp3008_responder #(.SYNC_STAGES(S), .DATA_W(10)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .din(din),
    .dout(dout), .dout_oe(dout_oe), .ch_data(ch_data),
    .conv_done(conv_done), .last_ch(last_ch), .last_sgl(last_sgl)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (conv_done) conv_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_ch;
    for (int i = 0; i < 8; i++) ch_data[10*i +: 10] = chv[i][9:0];
  endtask

  task automatic randomize_ch;
    for (int i = 0; i < 8; i++) chv[i] = int'($urandom_range(0, 1023));
    load_ch();
  endtask

  // Expected conversion value from the channel bank and the 4-bit command {SGL,D2,D1,D0}.
  function automatic int model(input logic [3:0] cmd);
    int c, p, n;
    c = int'(cmd[2:0]);
    if (cmd[3]) return chv[c];
    p = chv[c];
    n = chv[c ^ 1];
    return (p > n) ? p - n : 0;
  endfunction

  // Expected dout/oe after every sclk fall: silent until the null bit, then null, MSB-first, tail.
  function automatic void expect_stream(input int lead, input int res, input int nclk,
                                        output logic [63:0] d, output logic [63:0] o);
    bit q[$];
    q.push_back(1'b0);
    for (int b = 9; b >= 0; b--) q.push_back(res[b]);
`ifdef MCP3008_LSB_TAIL_EN
    for (int b = 1; b <= 9; b++) q.push_back(res[b]);
`endif
    d = '0;
    o = '0;
    for (int j = 0; j < nclk; j++) begin
      if (j >= lead + 4) begin
        o[j] = 1'b1;
        if (j - lead - 4 < q.size()) d[j] = q[j - lead - 4];
      end
    end
  endfunction

  function automatic logic [9:0] result_bits(input logic [63:0] dv, input int lead);
    logic [9:0] r;
    for (int k = 0; k < 10; k++) r[9-k] = dv[lead + 5 + k];
    return r;
  endfunction

  task automatic sclk_cycle(input logic b, output logic d, output logic o);
    din = b;
    tick(HALF);
    sclk = 1'b1;
    tick(HALF);
    sclk = 1'b0;
    tick(HALF - 1);
    @(negedge clk);
    d = dout;
    o = dout_oe;
  endtask

  task automatic spi_xfer(input int lead, input logic [3:0] cmd, input int nclk, input bit scramble,
                          output logic [63:0] dv, output logic [63:0] ov);
    logic b, d, o;
    dv = '0;
    ov = '0;
    conv_cnt = 0;
    cs_n = 1'b0;
    tick(HALF);
    for (int j = 0; j < nclk; j++) begin
      if (j < lead) b = 1'b0;
      else if (j == lead) b = 1'b1;
      else if (j <= lead + 4) b = cmd[lead + 4 - j];
      else b = 1'($urandom_range(0, 1));
      sclk_cycle(b, d, o);
      dv[j] = d;
      ov[j] = o;
      if (scramble && j == lead + 4) randomize_ch();
    end
  endtask

  task automatic close_cs;
    cs_n = 1'b1;
    tick(3 * HALF);
  endtask

  task automatic test_reset;
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; din = 1'b0; ch_data = '0;
    tick(4);
    total++; if (dout !== 1'b0) begin bad++; $display("FAIL reset_dout got=%b exp=0", dout); end
    total++; if (dout_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", dout_oe); end
    total++; if (conv_done !== 1'b0) begin bad++; $display("FAIL reset_conv got=%b exp=0", conv_done); end
    total++; if (last_ch !== 3'd0) begin bad++; $display("FAIL reset_last_ch got=%0d exp=0", last_ch); end
    total++; if (last_sgl !== 1'b0) begin bad++; $display("FAIL reset_last_sgl got=%b exp=0", last_sgl); end
    rst = 1'b0;
    tick(10);
  endtask

  task automatic test_single;
    logic [63:0] dv, ov, ed, eo;
    randomize_ch();
    chv[5] = 'h2A5; load_ch();
    spi_xfer(0, 4'b1101, 20, 1'b0, dv, ov);
    close_cs();
    expect_stream(0, 'h2A5, 20, ed, eo);
    total++; if (result_bits(dv, 0) !== 10'b1010100101) begin bad++; $display("FAIL single_bits got=%b exp=1010100101", result_bits(dv, 0)); end
    total++; if (dv[19:0] !== ed[19:0]) begin bad++; $display("FAIL single_dout got=%h exp=%h", dv[19:0], ed[19:0]); end
    total++; if (ov[19:0] !== eo[19:0]) begin bad++; $display("FAIL single_oe got=%h exp=%h", ov[19:0], eo[19:0]); end
    total++; if (conv_cnt !== 1) begin bad++; $display("FAIL single_conv got=%0d exp=1", conv_cnt); end
    total++; if (last_ch !== 3'd5) begin bad++; $display("FAIL single_last_ch got=%0d exp=5", last_ch); end
    total++; if (last_sgl !== 1'b1) begin bad++; $display("FAIL single_last_sgl got=%b exp=1", last_sgl); end
    total++; if (dout_oe !== 1'b0) begin bad++; $display("FAIL single_idle_oe got=%b exp=0", dout_oe); end
  endtask

  task automatic test_diff;
    logic [63:0] dv, ov, ed, eo;
    randomize_ch();
    chv[2] = 700; chv[3] = 200; load_ch();
    spi_xfer(0, 4'b0010, 16, 1'b0, dv, ov);
    close_cs();
    expect_stream(0, model(4'b0010), 16, ed, eo);
    total++; if (result_bits(dv, 0) !== 10'd500) begin bad++; $display("FAIL diff_pos got=%0d exp=500", result_bits(dv, 0)); end
    total++; if (dv[15:0] !== ed[15:0] || ov[15:0] !== eo[15:0]) begin bad++; $display("FAIL diff_pos_stream got=%h/%h exp=%h/%h", dv[15:0], ov[15:0], ed[15:0], eo[15:0]); end
    total++; if (last_sgl !== 1'b0 || last_ch !== 3'd2) begin bad++; $display("FAIL diff_last got=%b/%0d exp=0/2", last_sgl, last_ch); end
    chv[2] = 200; chv[3] = 700; load_ch();
    spi_xfer(0, 4'b0010, 16, 1'b0, dv, ov);
    close_cs();
    total++; if (result_bits(dv, 0) !== 10'd0) begin bad++; $display("FAIL diff_neg got=%0d exp=0", result_bits(dv, 0)); end
    total++; if (conv_cnt !== 1) begin bad++; $display("FAIL diff_conv got=%0d exp=1", conv_cnt); end
  endtask

  task automatic test_tail;
    logic [63:0] dv, ov, ed, eo;
    logic [8:0]  tail9, exp9;
    randomize_ch();
    chv[1] = 'h301; load_ch();
    spi_xfer(0, 4'b1001, 30, 1'b0, dv, ov);
    expect_stream(0, 'h301, 30, ed, eo);
    for (int k = 0; k < 9; k++) tail9[k] = dv[15 + k];
`ifdef MCP3008_LSB_TAIL_EN
    exp9 = 9'b110000000;
`else
    exp9 = 9'b000000000;
`endif
    total++; if (tail9 !== exp9) begin bad++; $display("FAIL tail_bits got=%b exp=%b", tail9, exp9); end
    total++; if (dv[29:24] !== 6'd0) begin bad++; $display("FAIL tail_zeros got=%b exp=000000", dv[29:24]); end
    total++; if (dv[29:0] !== ed[29:0] || ov[29:0] !== eo[29:0]) begin bad++; $display("FAIL tail_stream got=%h/%h exp=%h/%h", dv[29:0], ov[29:0], ed[29:0], eo[29:0]); end
    total++; if (dout_oe !== 1'b1) begin bad++; $display("FAIL tail_oe_hold got=%b exp=1", dout_oe); end
    close_cs();
  endtask

  task automatic test_abort;
    logic [63:0] dv, ov, ed, eo;
    randomize_ch();
    chv[0] = 'h3FF; load_ch();
    spi_xfer(0, 4'b1000, 4, 1'b0, dv, ov);
    cs_n = 1'b1;
    tick(S + 2);
    total++; if (dout_oe !== 1'b0) begin bad++; $display("FAIL abort_oe got=%b exp=0", dout_oe); end
    total++; if (conv_cnt !== 0 || ov[3:0] !== 4'd0) begin bad++; $display("FAIL abort_conv got=%0d/%b exp=0/0000", conv_cnt, ov[3:0]); end
    tick(2 * HALF);
    spi_xfer(0, 4'b1000, 16, 1'b0, dv, ov);
    close_cs();
    expect_stream(0, 'h3FF, 16, ed, eo);
    total++; if (result_bits(dv, 0) !== 10'h3FF) begin bad++; $display("FAIL abort_next got=%b exp=1111111111", result_bits(dv, 0)); end
    total++; if (dv[15:0] !== ed[15:0] || ov[15:0] !== eo[15:0]) begin bad++; $display("FAIL abort_next_stream got=%h/%h exp=%h/%h", dv[15:0], ov[15:0], ed[15:0], eo[15:0]); end
  endtask

  task automatic test_sweep;
    logic [63:0] dv, ov, ed, eo;
    for (int i = 0; i < 8; i++) chv[i] = i * 100;
    load_ch();
    for (int i = 0; i < 8; i++) begin
      spi_xfer(8, {1'b1, 3'(i)}, 23, 1'b0, dv, ov);
      close_cs();
      expect_stream(8, i * 100, 23, ed, eo);
      total++; if (result_bits(dv, 8) !== 10'(i * 100)) begin bad++; $display("FAIL sweep_val ch=%0d got=%0d exp=%0d", i, result_bits(dv, 8), i * 100); end
      total++; if (dv[22:0] !== ed[22:0] || ov[22:0] !== eo[22:0]) begin bad++; $display("FAIL sweep_stream ch=%0d got=%h/%h exp=%h/%h", i, dv[22:0], ov[22:0], ed[22:0], eo[22:0]); end
      total++; if (last_ch !== 3'(i)) begin bad++; $display("FAIL sweep_last_ch got=%0d exp=%0d", last_ch, i); end
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] dv, ov, ed, eo;
    logic d, o, oe_any;
    randomize_ch();
    chv[5] = 'h155; load_ch();
    spi_xfer(0, 4'b1101, 8, 1'b0, dv, ov);
    total++; if (ov[7] !== 1'b1) begin bad++; $display("FAIL rmid_pre_oe got=%b exp=1", ov[7]); end
    rst = 1'b1;
    #1;
    total++; if (dout_oe !== 1'b0 || dout !== 1'b0) begin bad++; $display("FAIL rmid_async got=%b/%b exp=0/0", dout_oe, dout); end
    total++; if (last_ch !== 3'd0) begin bad++; $display("FAIL rmid_last_ch got=%0d exp=0", last_ch); end
    tick(3);
    rst = 1'b0;
    conv_cnt = 0;
    oe_any = 1'b0;
    for (int j = 0; j < 20; j++) begin
      sclk_cycle((j == 0 || j == 1 || j == 2 || j == 4) ? 1'b1 : 1'b0, d, o);
      oe_any = oe_any | o;
    end
    total++; if (oe_any !== 1'b0 || conv_cnt !== 0) begin bad++; $display("FAIL rmid_no_resp got=%b/%0d exp=0/0", oe_any, conv_cnt); end
    close_cs();
    spi_xfer(0, 4'b1101, 16, 1'b0, dv, ov);
    close_cs();
    expect_stream(0, 'h155, 16, ed, eo);
    total++; if (dv[15:0] !== ed[15:0] || ov[15:0] !== eo[15:0]) begin bad++; $display("FAIL rmid_resume got=%h/%h exp=%h/%h", dv[15:0], ov[15:0], ed[15:0], eo[15:0]); end
  endtask

  task automatic test_random;
    logic [63:0] dv, ov, ed, eo;
    logic [3:0]  cmd;
    int lead, res, n;
    for (int t = 0; t < 8; t++) begin
      randomize_ch();
      cmd  = 4'($urandom_range(0, 15));
      lead = int'($urandom_range(0, 3));
      n    = lead + 26;
      res  = model(cmd);
      spi_xfer(lead, cmd, n, 1'b1, dv, ov);
      close_cs();
      expect_stream(lead, res, n, ed, eo);
      total++; if (dv !== ed || ov !== eo) begin bad++; $display("FAIL rand_stream t=%0d cmd=%b got=%h/%h exp=%h/%h", t, cmd, dv, ov, ed, eo); end
      total++; if (conv_cnt !== 1 || last_ch !== cmd[2:0] || last_sgl !== cmd[3]) begin bad++; $display("FAIL rand_status t=%0d got=%0d/%0d/%b exp=1/%0d/%b", t, conv_cnt, last_ch, last_sgl, cmd[2:0], cmd[3]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_diff();
    test_tail();
    test_abort();
    test_sweep();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
